ysyx_22050854_clint: RTL and testbench

- Core-local interruptor (CLINT) holding the 64-bit mtime counter, the mtimecmp register and the software-interrupt bit msip.
- Sits on the LSU's memory-mapped side and directly feeds the CSR register file.
- Drives mtime_bigger_mtimecmp, which the CSR file gates with mstatus.MIE/mie.MTIE to set mip.MTIP.
- Drives msip for the future software-interrupt path.

---
 rtl/ysyx_22050854_clint_pkg.sv | 60 ++++++
 rtl/ysyx_22050854_byte_merge.sv | 20 ++
 rtl/ysyx_22050854_clint.sv | 138 +++++++++++++
 tb/tb_ysyx_22050854_clint.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_clint_pkg.sv
// Shared definitions for the CLINT and the other memory-mapped slaves on the
// LSU side: bus field widths, CLINT register offsets and small helpers.
package ysyx_22050854_clint_pkg;

  // Bus request/response field widths, reused by every MMIO slave.
  localparam int BUS_ADDR_W = 64;
  localparam int BUS_DATA_W = 64;
  localparam int BUS_STRB_W = BUS_DATA_W / 8;

  // Default CLINT window and register offsets inside it.
  localparam logic [63:0] CLINT_BASE         = 64'h0000_0000_0200_0000;
  localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  // mtimecmp resets to all-ones so the timer cannot fire before software
  // programs it.
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Register selected by one bus access.
  typedef enum logic [1:0] {
    SEL_NONE     = 2'd0,
    SEL_MSIP     = 2'd1,
    SEL_MTIMECMP = 2'd2,
    SEL_MTIME    = 2'd3
  } clint_sel_e;

  // Expand per-byte write strobes into a per-bit mask.
  function automatic logic [BUS_DATA_W-1:0] strb_to_mask(
    input logic [BUS_STRB_W-1:0] strb
  );
    logic [BUS_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < BUS_STRB_W; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  // Map a window offset to a register; misaligned or unmapped -> SEL_NONE.
  function automatic clint_sel_e clint_decode(
    input logic [63:0] offset,
    input logic [2:0]  addr_lo
  );
    clint_sel_e sel;
    if (addr_lo != 3'd0) begin
      sel = SEL_NONE;
    end else if (offset == CLINT_MSIP_OFF) begin
      sel = SEL_MSIP;
    end else if (offset == CLINT_MTIMECMP_OFF) begin
      sel = SEL_MTIMECMP;
    end else if (offset == CLINT_MTIME_OFF) begin
      sel = SEL_MTIME;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_22050854_byte_merge.sv
// Byte-granular write merge: bytes with a set strobe take the write data,
// the others keep the old value.
module ysyx_22050854_byte_merge
  import ysyx_22050854_clint_pkg::*;
(
  input  logic [BUS_DATA_W-1:0] old_data,
  input  logic [BUS_DATA_W-1:0] wdata,
  input  logic [BUS_STRB_W-1:0] wstrb,
  output logic [BUS_DATA_W-1:0] new_data
);

  logic [BUS_DATA_W-1:0] mask_s;

  // Build the bit mask and blend old and new data through it.
  always_comb begin
    mask_s   = strb_to_mask(wstrb);
    new_data = (old_data & ~mask_s) | (wdata & mask_s);
  end

endmodule

// File: rtl/ysyx_22050854_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a valid/ready bus port
// with a one-entry response buffer and fixed one-cycle response latency.
module ysyx_22050854_clint
  import ysyx_22050854_clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = CLINT_BASE,
  parameter int          TICK_DIV  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BUS_ADDR_W-1:0] req_addr,
  input  logic                  req_wen,
  input  logic [BUS_DATA_W-1:0] req_wdata,
  input  logic [BUS_STRB_W-1:0] req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BUS_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mtime_bigger_mtimecmp,
  output logic                  msip
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        msip_r;
  logic [15:0] presc_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [63:0] resp_rdata_r;

  logic        accept_s;
  logic        wr_s;
  logic        tick_s;
  logic [63:0] offset_s;
  clint_sel_e  sel_s;
  logic [63:0] lookup_s;
  logic [63:0] resp_data_s;
  logic [63:0] mtime_inc_s;
  logic [63:0] mtime_merged_s;
  logic [63:0] mtimecmp_merged_s;

  assign req_ready   = !resp_valid_r || resp_ready;
  assign accept_s    = req_valid && req_ready;
  assign wr_s        = accept_s && req_wen;
  assign offset_s    = req_addr - BASE_ADDR;
  assign tick_s      = (presc_r == TICK_LAST);
  assign mtime_inc_s = tick_s ? (mtime_r + 64'd1) : mtime_r;

  // Decode the access and pick the read data; writes and errors return 0.
  always_comb begin
    sel_s = clint_decode(offset_s, req_addr[2:0]);
    case (sel_s)
      SEL_MSIP:     lookup_s = {63'd0, msip_r};
      SEL_MTIMECMP: lookup_s = mtimecmp_r;
      SEL_MTIME:    lookup_s = mtime_r;
      default:      lookup_s = 64'd0;
    endcase
    if (req_wen) begin
      resp_data_s = 64'd0;
    end else begin
      resp_data_s = lookup_s;
    end
  end

  // A write to mtime lands on top of this cycle's incremented value, so
  // unwritten bytes still advance.
  ysyx_22050854_byte_merge u_mtime_merge (
    .old_data (mtime_inc_s),
    .wdata    (req_wdata),
    .wstrb    (req_wstrb),
    .new_data (mtime_merged_s)
  );

  ysyx_22050854_byte_merge u_mtimecmp_merge (
    .old_data (mtimecmp_r),
    .wdata    (req_wdata),
    .wstrb    (req_wstrb),
    .new_data (mtimecmp_merged_s)
  );

  // Prescaler and mtime: advance on prescaler wrap, bus writes take priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_r <= 16'd0;
      mtime_r <= 64'd0;
    end else begin
      presc_r <= tick_s ? 16'd0 : (presc_r + 16'd1);
      if (wr_s && (sel_s == SEL_MTIME)) begin
        mtime_r <= mtime_merged_s;
      end else begin
        mtime_r <= mtime_inc_s;
      end
    end
  end

  // mtimecmp and msip software-visible registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtimecmp_r <= CLINT_MTIMECMP_RST;
      msip_r     <= 1'b0;
    end else begin
      if (wr_s && (sel_s == SEL_MTIMECMP)) begin
        mtimecmp_r <= mtimecmp_merged_s;
      end
      if (wr_s && (sel_s == SEL_MSIP) && req_wstrb[0]) begin
        msip_r <= req_wdata[0];
      end
    end
  end

  // One-entry response buffer: load on accept, clear once consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 64'd0;
    end else if (accept_s) begin
      resp_valid_r <= 1'b1;
      resp_err_r   <= (sel_s == SEL_NONE);
      resp_rdata_r <= resp_data_s;
    end else if (resp_ready) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 64'd0;
    end
  end

  assign resp_valid            = resp_valid_r;
  assign resp_err              = resp_err_r;
  assign resp_rdata            = resp_rdata_r;
  assign mtime_bigger_mtimecmp = (mtime_r >= mtimecmp_r);
  assign msip                  = msip_r;

endmodule

// File: tb/tb_ysyx_22050854_clint.sv
// Self-checking bench for the CLINT: directed steps followed by random bus
// traffic, checked against a timeline model of mtime (anchor value + elapsed
// cycles) and plain copies of mtimecmp/msip.
module tb_ysyx_22050854_clint;

  localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
  localparam logic [63:0] OFF_MSIP = 64'h0;
  localparam logic [63:0] OFF_CMP  = 64'h4000;
  localparam logic [63:0] OFF_TIME = 64'hBFF8;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  // main DUT, TICK_DIV = 1
  logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b1;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic [7:0]  req_wstrb = 8'd0;
  logic        req_ready, resp_valid, resp_err, cmp_o, msip_o;
  logic [63:0] resp_rdata;

  // second DUT, TICK_DIV = 4
  logic        req_valid4 = 1'b0, req_wen4 = 1'b0, resp_ready4 = 1'b1;
  logic [63:0] req_addr4 = 64'd0, req_wdata4 = 64'd0;
  logic [7:0]  req_wstrb4 = 8'd0;
  logic        req_ready4, resp_valid4, resp_err4, cmp4_o, msip4_o;
  logic [63:0] resp_rdata4;

  int              n_cmp = 0;
  int              n_bad = 0;
  longint unsigned cyc = 0;

  // model state
  longint unsigned m_anchor_k;
  logic [63:0]     m_anchor_v;
  logic [63:0]     m_cmp;
  logic            m_msip;

  ysyx_22050854_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mtime_bigger_mtimecmp(cmp_o), .msip(msip_o)
  );

  ysyx_22050854_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_addr(req_addr4),
    .req_wen(req_wen4), .req_wdata(req_wdata4), .req_wstrb(req_wstrb4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_rdata(resp_rdata4),
    .resp_err(resp_err4), .mtime_bigger_mtimecmp(cmp4_o), .msip(msip4_o)
  );

  always #5 clock = ~clock;

  // edge counter used as the model's time base
  always @(posedge clock) cyc <= cyc + 64'd1;

  // hard stop if something hangs
  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mtime as held after edge k
  function automatic logic [63:0] mtime_at(input longint unsigned k);
    return m_anchor_v + 64'(k - m_anchor_k);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] ws);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (ws[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic bit mapped(input logic [63:0] off);
    return (off == OFF_MSIP) || (off == OFF_CMP) || (off == OFF_TIME);
  endfunction

  task automatic model_reset();
    m_anchor_k = cyc;
    m_anchor_v = 64'd0;
    m_cmp      = ONES;
    m_msip     = 1'b0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_cmp"}, 64'(cmp_o), 64'(mtime_at(cyc) >= m_cmp));
    chk({tag, "_msip"}, 64'(msip_o), 64'(m_msip));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      chk_outs("idle");
    end
  endtask

  // one bus access on the main DUT, accepted at the next edge
  task automatic bus(input logic wen, input logic [63:0] off, input logic [63:0] wd,
                     input logic [7:0] ws, input string tag, output logic [63:0] rd);
    logic [63:0] exp_rd;
    logic        exp_err;
    longint unsigned k;
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = BASE + off;
    req_wdata = wd; req_wstrb = ws;
    @(posedge clock); #1;
    k = cyc;
    req_valid = 1'b0;
    exp_err = !mapped(off) || (off[2:0] != 3'd0);
    exp_rd  = 64'd0;
    if (!exp_err && !wen) begin
      if (off == OFF_MSIP)     exp_rd = 64'(m_msip);
      else if (off == OFF_CMP) exp_rd = m_cmp;
      else                     exp_rd = mtime_at(k - 1);
    end else if (!exp_err && wen) begin
      if (off == OFF_MSIP) begin
        if (ws[0]) m_msip = wd[0];
      end else if (off == OFF_CMP) begin
        m_cmp = merge(m_cmp, wd, ws);
      end else begin
        m_anchor_v = merge(mtime_at(k - 1) + 64'd1, wd, ws);
        m_anchor_k = k;
      end
    end
    rd = resp_rdata;
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
    chk_outs(tag);
  endtask

  // read on the TICK_DIV = 4 DUT
  task automatic bus4_read(input logic [63:0] off, output logic [63:0] rd, output logic err);
    req_valid4 = 1'b1; req_wen4 = 1'b0; req_addr4 = BASE + off; req_wstrb4 = 8'd0;
    @(posedge clock); #1;
    req_valid4 = 1'b0;
    rd  = resp_rdata4;
    err = resp_err4;
  endtask

  initial begin
    logic [63:0]     rd, held, wd, off;
    logic            e4;
    longint unsigned k0, kw, k_rise, k;
    int              r;

    // ---------------- reset state ----------------
    @(posedge clock); #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_cmp", 64'(cmp_o), 64'd0);
    chk("rst_msip", 64'(msip_o), 64'd0);
    chk("rst4_cmp", 64'(cmp4_o), 64'd0);
    reset = 1'b1;
    k0 = cyc;
    model_reset();

    // ---------------- TICK_DIV = 4: idle 40 cycles ----------------
    idle(40);
    bus4_read(OFF_TIME, rd, e4);
    chk("div4_mtime", rd, 64'((cyc - 1 - k0) / 4));
    chk("div4_mtime_is_10", rd, 64'd10);
    chk("div4_err", 64'(e4), 64'd0);
    bus4_read(OFF_CMP, rd, e4);
    chk("div4_cmp_reg", rd, ONES);
    chk("div4_cmp_out", 64'(cmp4_o), 64'd0);

    // ---------------- compare rises at 20, drops on raise ----------------
    bus(1'b1, OFF_TIME, 64'd5, 8'hFF, "wr_mtime5", rd);
    kw = cyc;
    bus(1'b1, OFF_CMP, 64'd20, 8'hFF, "wr_cmp20", rd);
    k_rise = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      chk_outs("rise_poll");
      if (cmp_o === 1'b1 && k_rise == 0) k_rise = cyc;
    end
    chk("rise_cycle", 64'(k_rise), 64'(kw + 15));
    chk("rise_held", 64'(cmp_o), 64'd1);
    bus(1'b1, OFF_CMP, 64'd1000, 8'hFF, "wr_cmp1000", rd);
    chk("drop_after_raise", 64'(cmp_o), 64'd0);

    // ---------------- mtime wrap ----------------
    bus(1'b1, OFF_CMP, ONES, 8'hFF, "wr_cmp_ones", rd);
    bus(1'b1, OFF_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, "wr_mtime_fffe", rd);
    chk("wrap_cmp_before", 64'(cmp_o), 64'd0);
    idle(1);
    chk("wrap_cmp_at_max", 64'(cmp_o), 64'd1);
    bus(1'b0, OFF_TIME, 64'd0, 8'h00, "rd_mtime_max", rd);
    chk("wrap_rd_max", rd, ONES);
    chk("wrap_cmp_after", 64'(cmp_o), 64'd0);
    bus(1'b0, OFF_TIME, 64'd0, 8'h00, "rd_mtime_zero", rd);
    chk("wrap_rd_zero", rd, 64'd0);

    // ---------------- byte strobes, msip ----------------
    bus(1'b1, OFF_CMP, 64'hAABB, 8'h01, "wr_cmp_byte0", rd);
    bus(1'b0, OFF_CMP, 64'd0, 8'h00, "rd_cmp_byte0", rd);
    chk("strb_cmp", rd, 64'hFFFF_FFFF_FFFF_FFBB);
    bus(1'b1, OFF_MSIP, 64'hFFFF_FFFF, 8'h0F, "wr_msip", rd);
    chk("msip_out", 64'(msip_o), 64'd1);
    bus(1'b0, OFF_MSIP, 64'd0, 8'h00, "rd_msip", rd);
    chk("msip_rd", rd, 64'd1);
    bus(1'b1, OFF_CMP, 64'd0, 8'h00, "wr_strb0", rd);

    // ---------------- back-pressure ----------------
    idle(1);
    resp_ready = 1'b0;
    bus(1'b0, OFF_CMP, 64'd0, 8'h00, "bp_rd", rd);
    held = rd;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + OFF_TIME; req_wstrb = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata", resp_rdata, held);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    k = cyc;
    req_valid = 1'b0;
    chk("bp_next_valid", 64'(resp_valid), 64'd1);
    chk("bp_next_rdata", resp_rdata, mtime_at(k - 1));

    // ---------------- errors ----------------
    bus(1'b0, 64'h1000, 64'd0, 8'h00, "err_1000", rd);
    chk("err_1000_flag", 64'(resp_err), 64'd1);
    bus(1'b0, 64'h4004, 64'd0, 8'h00, "err_4004", rd);
    chk("err_4004_rd", rd, 64'd0);
    bus(1'b1, 64'h4004, 64'd0, 8'hFF, "err_wr_4004", rd);
    bus(1'b0, OFF_CMP, 64'd0, 8'h00, "err_cmp_kept", rd);
    chk("err_cmp_unchanged", rd, 64'hFFFF_FFFF_FFFF_FFBB);

    // ---------------- reset with a pending response ----------------
    idle(1);
    resp_ready = 1'b0;
    bus(1'b0, OFF_MSIP, 64'd0, 8'h00, "pre_rst_rd", rd);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_msip", 64'(msip_o), 64'd0);
    chk("midrst_cmp", 64'(cmp_o), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    resp_ready = 1'b1;
    model_reset();
    idle(3);

    // ---------------- random traffic ----------------
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          case ($urandom_range(0, 2))
            0:       off = OFF_MSIP;
            1:       off = OFF_CMP;
            default: off = OFF_TIME;
          endcase
          bus(1'b0, off, 64'd0, 8'h00, "rnd_rd", rd);
        end
        3: begin
          if ($urandom_range(0, 1) == 1) wd = mtime_at(cyc) + 64'($urandom_range(0, 6));
          else                           wd = {$urandom, $urandom};
          bus(1'b1, OFF_CMP, wd, 8'($urandom), "rnd_wr_cmp", rd);
        end
        4: bus(1'b1, OFF_TIME, {$urandom, $urandom}, 8'($urandom), "rnd_wr_time", rd);
        5: bus(1'b1, OFF_MSIP, {$urandom, $urandom}, 8'($urandom), "rnd_wr_msip", rd);
        6: begin
          off = 64'($urandom_range(1, 6)) * 64'h2000 + 64'h8;
          bus(1'($urandom), off, {$urandom, $urandom}, 8'hFF, "rnd_unmapped", rd);
        end
        7: begin
          off = OFF_CMP + 64'($urandom_range(1, 7));
          bus(1'($urandom), off, {$urandom, $urandom}, 8'hFF, "rnd_misalign", rd);
        end
        8: idle($urandom_range(1, 3));
        default: bus(1'b1, OFF_TIME, {$urandom, $urandom}, 8'h00, "rnd_strb0", rd);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
